// File: rtl/wide_sub_seq.sv
// Multi-cycle wide unsigned subtractor: out = in1 - in2, CHUNK bits per clock with a registered borrow chain.
// Optional signed-overflow flag on port ovf when SUB_SIGNED_OVF_EN is defined.
module wide_sub_seq #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] d_k;
    logic             b_k_out;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // One chunk of the subtraction; the extra top bit of the difference is the chunk's borrow out.
    always_comb begin
        a_k                              = a_reg[int'(cnt)*CHUNK +: CHUNK];
        b_k                              = b_reg[int'(cnt)*CHUNK +: CHUNK];
        {b_k_out, d_k}                   = {1'b0, a_k} - {1'b0, b_k} - (CHUNK + 1)'(borrow);
        res_next                         = res_reg;
        res_next[int'(cnt)*CHUNK +: CHUNK] = d_k;
    end

    // NOTE: operand and working-result registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= in1;
            b_reg <= in2;
        end
        if (state == RUN) res_reg <= res_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            borrow     <= 1'b0;
            out        <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                borrow <= 1'b0;
            end else if (state == RUN) begin
                cnt    <= cnt + 1'b1;
                borrow <= b_k_out;
                if (last) begin
                    out        <= res_next;
                    borrow_out <= b_k_out;
                    done       <= 1'b1;
                end
            end
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    // Operands of differing sign overflow when the result's sign departs from the minuend's.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end
`else
    // Without the overflow option the operand sign bits feed only the chunk path above.
`endif

endmodule

// File: tb/tb_wide_sub_seq.sv
// Self-checking bench for wide_sub_seq: per-cycle compare against a whole-word arithmetic model,
// plus directed literal checks. Honours SUB_SIGNED_OVF_EN when defined.
module tb_wide_sub_seq;

    localparam int W     = 1024;
    localparam int CHUNK = 64;
    localparam int N     = W / CHUNK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [W-1:0] out;
    logic         borrow_out;
    logic         busy;
    logic         done;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    wide_sub_seq #(.WIDTH(W), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in1        (in1),
        .in2        (in2),
        .out        (out),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ..%0h expected ..%0h (low 128 bits shown)", name, act[127:0], exp[127:0]);
        end
    endtask

    // Whole-word model: an accepted start produces in1-in2 exactly N edges later.
    logic [W-1:0] m_a, m_b, m_out;
    logic         m_borrow, m_busy, m_done, m_ovf;
    int           m_left;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_out <= '0; m_borrow <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_out    <= m_a - m_b;
                    m_borrow <= (m_a < m_b);
                    m_ovf    <= (m_a[W-1] != m_b[W-1]) && (((m_a - m_b) >> (W - 1)) != W'(m_a[W-1]));
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_a <= in1; m_b <= in2; m_busy <= 1'b1; m_left <= N;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", W'(busy), W'(m_busy));
            check("done", W'(done), W'(m_done));
            check("out", out, m_out);
            check("borrow_out", W'(borrow_out), W'(m_borrow));
`ifdef SUB_SIGNED_OVF_EN
            check("ovf", W'(ovf), W'(m_ovf));
`endif
        end
    end

    int e0;

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", W'(done), W'(1));
        lat = cyc - e0;
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y;
        int lat;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_out", out, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_borrow", W'(borrow_out), '0);

        // 1: small subtract, latency
        do_op(W'(5), W'(3));
        check("t1_busy", W'(busy), W'(1));
        wait_done(lat);
        check("t1_latency", W'(lat), W'(16));
        check("t1_out", out, W'(2));
        check("t1_borrow", W'(borrow_out), W'(0));

        // 2: full-width borrow
        do_op(W'(0), W'(1));
        wait_done(lat);
        check("t2_out", out, {W{1'b1}});
        check("t2_borrow", W'(borrow_out), W'(1));

        // 3: borrow crossing chunk 0 -> chunk 1
        x = '0; x[64] = 1'b1;
        do_op(x, W'(1));
        wait_done(lat);
        check("t3_lo", W'(out[63:0]), W'(64'hFFFF_FFFF_FFFF_FFFF));
        check("t3_hi", W'(out[W-1:64]), '0);
        check("t3_borrow", W'(borrow_out), W'(0));

        // 4: start while busy ignored; start in done cycle accepted
        do_op(W'(100), W'(58));
        repeat (4) @(negedge clk);
        in1 = W'(1000); in2 = W'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("t4_out", out, W'(42));
        check("t4_latency", W'(lat), W'(16));
        in1 = W'(7); in2 = W'(9); start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("t4_reaccept_busy", W'(busy), W'(1));
        wait_done(lat);
        check("t4b_out", out, {{(W-1){1'b1}}, 1'b0});
        check("t4b_borrow", W'(borrow_out), W'(1));

        // 5: reset mid-run aborts
        do_op(W'(9), W'(4));
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_out", out, '0);
        check("t5_busy", W'(busy), '0);
        check("t5_done", W'(done), '0);
        repeat (20) @(negedge clk);
        do_op(W'(9), W'(4));
        wait_done(lat);
        check("t5_out_after", out, W'(5));

        // 6: signed overflow corner and equal operands
        x = '0; x[W-1] = 1'b1;
        do_op(x, W'(1));
        wait_done(lat);
        check("t6_out", out, {1'b0, {(W-1){1'b1}}});
        check("t6_borrow", W'(borrow_out), W'(0));
`ifdef SUB_SIGNED_OVF_EN
        check("t6_ovf", W'(ovf), W'(1));
`endif
        x = rand_wide();
        do_op(x, x);
        wait_done(lat);
        check("t6_eq_out", out, '0);
        check("t6_eq_borrow", W'(borrow_out), W'(0));
`ifdef SUB_SIGNED_OVF_EN
        check("t6_eq_ovf", W'(ovf), W'(0));
`endif

        // Random pairs; the per-cycle compare checks each against in1-in2
        for (int i = 0; i < 1000; i++) begin
            x = rand_wide();
            y = (i % 50 == 0) ? x : rand_wide();
            do_op(x, y);
            wait_done(lat);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
